// File: rtl/add_subb_serial.sv
// Bit-serial add/subtract of two signed W-bit operands, LSB first, one bit per clock.
// Result is valid W cycles after acceptance; a new operand set is accepted only in IDLE.
module add_subb_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         subb_a,
  input  logic         subb_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c,
  output logic         busy
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_sh, b_sh;
  logic           neg_a, neg_b;
  logic           seen_a, seen_b;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           last_bit;
  logic           bit_a, bit_b;
  logic           sum, cout;

  assign last_bit = (cnt == CW'(W - 1));

  // Serial two's-complement negation: pass bits through up to and including
  // the first 1, invert every bit after it.
  always_comb begin
    bit_a = a_sh[0] ^ (neg_a & seen_a);
    bit_b = b_sh[0] ^ (neg_b & seen_b);
    sum   = bit_a ^ bit_b ^ carry;
    cout  = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      seen_a <= 1'b0;
      seen_b <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      c      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            neg_a  <= subb_a;
            neg_b  <= subb_b;
            seen_a <= 1'b0;
            seen_b <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          seen_a <= seen_a | a_sh[0];
          seen_b <= seen_b | b_sh[0];
          carry  <= cout;
          cnt    <= cnt + CW'(1);
          // Sum bits enter at the MSB so bit 0 lands at s[0] after W shifts.
          s      <= {sum, s[W-1:1]};
          if (last_bit) c <= cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign out_valid = (state == DONE);

endmodule

// File: doc/add_subb_serial.md
ADD_SUBB_SERIAL -- requirements
Module: add_subb_serial

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand and result width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low; the block is in reset while rst=0.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 The block SHALL have port subb_a, input, 1 bit: negate operand a.
REQ-007 The block SHALL have port subb_b, input, 1 bit: negate operand b.
REQ-008 The block SHALL have port a, input, W bits: signed two's-complement operand a.
REQ-009 The block SHALL have port b, input, W bits: signed two's-complement operand b.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result on s and c is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port s, output, W bits: signed result.
REQ-013 The block SHALL have port c, output, 1 bit: carry out of the result.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the block is in state CALC.

Function
REQ-015 The result SHALL be bit-exact with the parallel add_subb block: A' = subb_a ? (2^W - a) mod 2^W : a, B' = subb_b ? (2^W - b) mod 2^W : b, X = A' + B' as an unsigned (W+1)-bit sum, s = X[W-1:0], c = X[W].
REQ-016 The block SHALL implement a state machine with states IDLE, CALC and DONE; reset state is IDLE.
REQ-017 The output in_ready SHALL equal 1 exactly when the state is IDLE; it is a combinational decode of the state only.
REQ-018 In IDLE, in_valid=1 at a rising edge SHALL capture a, b, subb_a and subb_b into internal registers, clear the bit counter and the carry, and move the state to CALC.
REQ-019 In CALC, each rising edge SHALL process exactly one bit position, LSB first, in the order 0..W-1.
REQ-020 CALC processing SHALL negate each operand serially (copy bits up to and including the first 1, invert all later bits) when its subb flag is set, add the two resulting bits with a 1-bit carry register, and shift the sum bit into the result register.
REQ-021 The bit counter SHALL be ceil(log2(W))+1 bits wide and SHALL NOT wrap within an operation.
REQ-022 After the edge that processes bit W-1, the state SHALL be DONE, c SHALL hold the final carry, and out_valid SHALL be 1.
REQ-023 Latency: if the operand set is accepted at edge k, out_valid SHALL rise after edge k+W.
REQ-024 In DONE, s, c and out_valid SHALL hold stable until a rising edge with out_ready=1.
REQ-025 On that edge the block SHALL clear out_valid and return to IDLE; s and c SHALL keep their last values.
REQ-026 The block SHALL NOT accept new operands in the same edge that the result is taken; the minimum issue interval is W+2 cycles.
REQ-027 The inputs in_valid, a, b and the subb flags SHALL be ignored outside IDLE; the values captured at acceptance are used even if the inputs change later.
REQ-028 The input out_ready SHALL be ignored outside DONE.
REQ-029 The output busy SHALL be 1 exactly when the state is CALC.

Reset
REQ-030 When rst=0, the block SHALL immediately set state=IDLE, out_valid=0, s=0, c=0, busy=0, in_ready=1, and clear the counter, carry and operand registers, without waiting for a clock edge.
REQ-031 A reset asserted during CALC or DONE SHALL abort the operation; no out_valid pulse is produced for the aborted operation.
REQ-032 After rst returns to 1, the first rising edge SHALL be able to accept operands.

Verification (W=4)
REQ-033 The bench SHALL cover: a=3, b=2, no subb, accepted at edge k -> out_valid after edge k+4, s=0101, c=0.
REQ-034 The bench SHALL cover: a=-8, b=-8, no subb -> s=0000, c=1; and a=7, b=1, no subb -> s=1000, c=0.
REQ-035 The bench SHALL cover: subb_a=1, a=3, b=5 -> s=0010, c=1; and subb_a=subb_b=1, a=0, b=0 -> s=0000, c=0.
REQ-036 The bench SHALL cover: exhaustive sweep of all 1024 combinations of a, b, subb_a and subb_b, with out_ready held at 1, compared against the REQ-015 model -> zero mismatches and an issue interval of exactly 6 cycles.
REQ-037 The bench SHALL cover: out_ready held at 0 for 5 cycles in DONE -> s, c and out_valid are stable, and in_ready stays 0 throughout.
REQ-038 The bench SHALL cover: rst pulsed low after the second CALC cycle -> all outputs take their reset values asynchronously, no out_valid pulse occurs, and the next operand set completes correctly.
